uart_irq_scheduler: RTL

Interrupt scheduler and register-bus arbiter for the multi-port 16550 UART array. It watches the per-port interrupt lines, picks one pending port at a time in round-robin order, and reads that port's IIR over the shared byte register bus. It hands the captured {port, IIR} pair to the host as a single event. It sits between the AXI-to-register bridge (host master) and the UART register array, and the host master always has priority on the bus.

---
 rtl/uart_sched_pkg.sv | 29 ++
 rtl/uart_rr_pick.sv | 40 ++++
 rtl/uart_irq_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART interrupt scheduler: FSM state
// encoding, IIR register location and the port-pointer increment helper.
package uart_sched_pkg;

    localparam int          PORT_W        = 3;
    localparam logic [2:0]  IIR_REG       = 3'd2;
    localparam int          IIR_NOINT_BIT = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        READ    = 3'd2,
        HOLD    = 3'd3,
        DISCARD = 3'd4,
        GUARD   = 3'd5
    } sched_state_t;

    // Advance a port index by one, wrapping at the last implemented port.
    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] cur,
                                                   input int port_num);
        logic [PORT_W-1:0] nxt;
        nxt = cur + 1'b1;
        if (int'(cur) >= port_num - 1) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first requesting port at or
// after ptr, wrapping from PORT_NUM-1 back to 0.
module uart_rr_pick
    import uart_sched_pkg::*;
#(
    parameter int PORT_NUM = 8
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [PORT_W-1:0]   ptr,
    output logic [PORT_W-1:0]   idx,
    output logic                any
);

    logic [PORT_W-1:0]   w_rot_idx [PORT_NUM];
    logic [PORT_NUM-1:0] w_hit;

    // Slot gi of the rotated view is the port gi positions after ptr.
    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_rot
            logic [PORT_W:0] w_sum;
            assign w_sum = {1'b0, ptr} + (PORT_W+1)'(gi);
            assign w_rot_idx[gi] = (w_sum >= (PORT_W+1)'(PORT_NUM))
                                 ? PORT_W'(w_sum - (PORT_W+1)'(PORT_NUM))
                                 : w_sum[PORT_W-1:0];
            assign w_hit[gi] = req[w_rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = PORT_NUM - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                idx = w_rot_idx[k];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_irq_scheduler.sv
// Round-robin interrupt scheduler and register-bus arbiter for the UART array.
// Optional port enable mask is compiled in with `define UART_SCHED_MASK_EN.
module uart_irq_scheduler
    import uart_sched_pkg::*;
#(
    parameter int PORT_NUM     = 8,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [PORT_NUM-1:0] intr_i,
    input  logic [5:0]          h_adr_i,
    input  logic [7:0]          h_dat_i,
    input  logic                h_we_i,
    input  logic                h_re_i,
    output logic [7:0]          h_dat_o,
    output logic [5:0]          m_adr_o,
    output logic [7:0]          m_dat_o,
    output logic                m_we_o,
    output logic                m_re_o,
    input  logic [7:0]          m_dat_i,
    input  logic [PORT_NUM-1:0] mask_i,
    input  logic                mask_we_i,
    output logic                ev_valid_o,
    output logic [PORT_W-1:0]   ev_port_o,
    output logic [7:0]          ev_iir_o,
    input  logic                ev_ready_i
);

    localparam int GCNT_W = $clog2(GUARD_CYCLES + 1) + 1;

    sched_state_t        r_state, w_state_next;
    logic [PORT_NUM-1:0] r_intr;
    logic [PORT_W-1:0]   r_cur, w_cur_next;
    logic [PORT_W-1:0]   r_ptr, w_ptr_next;
    logic [7:0]          r_iir, w_iir_next;
    logic [GCNT_W-1:0]   r_gcnt, w_gcnt_next;

    logic [PORT_NUM-1:0] w_mask;
    logic [PORT_NUM-1:0] w_req;
    logic [PORT_W-1:0]   w_pick_idx;
    logic                w_pick_any;
    logic                w_host;
    logic                w_sched_re;
    logic                w_guard_done;

`ifdef UART_SCHED_MASK_EN
    logic [PORT_NUM-1:0] r_mask;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mask <= '1;
        end else if (mask_we_i) begin
            r_mask <= mask_i;
        end
    end

    assign w_mask = r_mask;
`else
    logic w_unused_mask;
    assign w_unused_mask = ^{mask_i, mask_we_i};
    assign w_mask        = '1;
`endif

    assign w_req  = r_intr & w_mask;
    assign w_host = h_we_i | h_re_i;

    uart_rr_pick #(
        .PORT_NUM (PORT_NUM)
    ) u_pick (
        .req (w_req),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_guard_done = (GUARD_CYCLES <= 1) ||
                          (r_gcnt >= GCNT_W'(GUARD_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        w_cur_next   = r_cur;
        w_ptr_next   = r_ptr;
        w_iir_next   = r_iir;
        w_gcnt_next  = r_gcnt;
        w_sched_re   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_next = SELECT;
                end
            end
            SELECT: begin
                // The request may have vanished since IDLE; nothing to read then.
                if (w_pick_any) begin
                    w_cur_next   = w_pick_idx;
                    w_state_next = READ;
                end else begin
                    w_state_next = IDLE;
                end
            end
            READ: begin
                if (!w_host) begin
                    w_sched_re   = 1'b1;
                    w_iir_next   = m_dat_i;
                    w_state_next = m_dat_i[IIR_NOINT_BIT] ? DISCARD : HOLD;
                end
            end
            HOLD: begin
                if (ev_ready_i) begin
                    w_ptr_next   = next_port(r_cur, PORT_NUM);
                    w_gcnt_next  = '0;
                    w_state_next = GUARD;
                end
            end
            DISCARD: begin
                w_ptr_next   = next_port(r_cur, PORT_NUM);
                w_gcnt_next  = '0;
                w_state_next = GUARD;
            end
            GUARD: begin
                if (w_guard_done) begin
                    w_state_next = IDLE;
                end else begin
                    w_gcnt_next = r_gcnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_intr  <= '0;
            r_cur   <= '0;
            r_ptr   <= '0;
            r_iir   <= '0;
            r_gcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_intr  <= intr_i;
            r_cur   <= w_cur_next;
            r_ptr   <= w_ptr_next;
            r_iir   <= w_iir_next;
            r_gcnt  <= w_gcnt_next;
        end
    end

    // Host always owns the bus when it strobes; the scheduler only ever reads IIR.
    always_comb begin
        m_adr_o = '0;
        m_dat_o = '0;
        m_we_o  = 1'b0;
        m_re_o  = 1'b0;
        if (w_host) begin
            m_adr_o = h_adr_i;
            m_dat_o = h_dat_i;
            m_we_o  = h_we_i;
            m_re_o  = h_re_i;
        end else if (w_sched_re) begin
            m_adr_o = {r_cur, IIR_REG};
            m_re_o  = 1'b1;
        end
    end

    assign h_dat_o    = m_dat_i;
    assign ev_valid_o = (r_state == HOLD);
    assign ev_port_o  = r_cur;
    assign ev_iir_o   = r_iir;

endmodule
